qpsk_upsampler: RTL
===================

Name: qpsk_upsampler

Overview:
- Upstream stage of the IQ root-raised-cosine FIR.
- Accepts a byte stream and splits it into 2-bit QPSK symbols, MSB pair first.
- Maps each symbol to offset-binary 8-bit I/Q levels and zero-stuffs by SPS: each symbol is followed by SPS-1 midscale samples.
- Presents one I/Q sample per FIR load request. Paced by the FIR's one-cycle ready pulse, which fires every 16 clocks.

Parameters:
- SPS, 2, samples per symbol (>=1); sample 0 of each symbol carries data, the rest are midscale.
- AMP, 90, symbol amplitude about midscale (1..127); "+" level = MID+AMP, "-" level = MID-AMP.
- MID, 128, offset-binary zero level emitted for stuffed samples and idle.

Ports:
- i_clk_x16  in  1  sample-rate x16 clock.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  clock enable; when low, all state and outputs hold and i_fir_ready is ignored.
- i_data  in  8  input byte, symbol order [7:6],[5:4],[3:2],[1:0].
- i_data_valid  in  1  i_data valid.
- o_data_ready  out  1  block can accept a byte this cycle.
- i_fir_ready  in  1  one-cycle pulse from FIR; next sample must be on o_I/o_Q at the following edge.
- o_I  out  8  offset-binary I sample, registered.
- o_Q  out  8  offset-binary Q sample, registered.
- o_sym_strobe  out  1  one-cycle pulse: o_I/o_Q just updated with a data symbol.
- o_underrun  out  1  one-cycle pulse: a data slot arrived with no symbol available; MID emitted instead.

Behaviour:
- Reset: i_rst is synchronous and active-high; the clock is i_clk_x16.
  - Values during and after reset: o_I=o_Q=MID, o_sym_strobe=0, o_underrun=0, shift register cleared, sym_cnt=0, phase=0.
  - o_data_ready=0 while i_rst is high and 1 on the first cycle after it drops.
  - Reset mid-byte discards the remaining symbols.
- State:
  - sreg[7:0], the current byte left-shifted as symbols are consumed.
  - sym_cnt 0..4, the number of symbols remaining.
  - phase 0..SPS-1.
- Input handshake:
  - o_data_ready = (sym_cnt==0), combinational from registered state.
  - Transfer occurs on cycles where i_en && i_data_valid && o_data_ready.
  - A transfer without an emit loads sreg<=i_data and sym_cnt<=4.
  - i_data_valid is ignored when not ready. The upstream must hold i_data until the transfer.
- Emit: advances on i_en && i_fir_ready. Outputs update at that edge, giving a latency of 1 cycle from the pulse.
  - phase != 0: o_I=o_Q=MID, no strobe.
  - phase==0 and sym_cnt>0:
    - Symbol bits are b1=sreg[7] and b0=sreg[6].
    - o_I = b1 ? MID-AMP : MID+AMP.
    - o_Q = b0 ? MID-AMP : MID+AMP.
    - sreg<=sreg<<2, sym_cnt<=sym_cnt-1, o_sym_strobe=1.
  - phase==0, sym_cnt==0, with a transfer in the same cycle (bypass):
    - Map i_data[7:6] as above.
    - sreg<=i_data<<2, sym_cnt<=3, o_sym_strobe=1.
  - phase==0, sym_cnt==0, no transfer:
    - o_I=o_Q=MID, o_underrun=1.
    - phase still advances, so stuffing cadence is preserved.
  - phase <= (phase==SPS-1) ? 0 : phase+1. With SPS=1, phase stays 0.
- Between emits, o_I/o_Q hold their last value. The FIR may sample on any cycle before the next pulse.
- Strobes are one cycle wide and deassert on the next enabled edge. With i_en low, the strobes also hold.
- Arithmetic: levels are computed as 9-bit and truncated to 8. Legal parameters (AMP<=127, MID=128) never wrap.

Test Plan:
- Reset, then one byte 0x1B with SPS=2, AMP=90, and i_fir_ready pulsed every 16 clocks.
  - Required (I,Q) sequence: (218,218),(128,128),(218,38),(128,128),(38,218),(128,128),(38,38),(128,128).
  - o_sym_strobe fires on samples 0, 2, 4 and 6.
  - o_data_ready returns to 1 after the fourth symbol.
- Starvation: no data after reset, 4 pulses.
  - Outputs stay 128/128.
  - o_underrun pulses on pulses 1 and 3 only (phase 0 slots).
- Bypass: byte 0xC0 presented in the same cycle as a phase-0 pulse with sym_cnt=0.
  - (38,38) appears on the next edge with no underrun.
  - Three (218,218) symbols follow at subsequent phase-0 slots.
- Back-to-back bytes 0x00 then 0xFF, valid held high.
  - Second byte is accepted only after the first byte's 4th symbol.
  - 4 symbols of (218,218) are followed by 4 of (38,38), with no underrun.
- Mid-byte reset after 2 symbols of 0x1B.
  - The next cycle gives o_I=o_Q=128 and o_data_ready=1.
  - The following byte's first symbol appears at the first pulse after reset.
- i_en low for 20 cycles spanning an i_fir_ready pulse.
  - Outputs, phase and sym_cnt are unchanged and the pulse is lost.
  - Resume matches the golden sequence shifted by one sample period.

Source files
------------

// File: rtl/qpsk_upsampler_if.sv
// Byte-in / sample-out bus of the QPSK upsampler: upstream byte handshake,
// FIR load pulse and the registered I/Q sample with its status strobes.
interface qpsk_upsampler_if;
  logic [7:0] i_data;
  logic       i_data_valid;
  logic       o_data_ready;
  logic       i_fir_ready;
  logic [7:0] o_I;
  logic [7:0] o_Q;
  logic       o_sym_strobe;
  logic       o_underrun;

  modport master (
    output i_data, i_data_valid, i_fir_ready,
    input  o_data_ready, o_I, o_Q, o_sym_strobe, o_underrun
  );

  modport slave (
    input  i_data, i_data_valid, i_fir_ready,
    output o_data_ready, o_I, o_Q, o_sym_strobe, o_underrun
  );
endinterface

// File: rtl/qpsk_upsampler.sv
// Splits bytes into 2-bit QPSK symbols (MSB pair first), maps them to offset-binary
// I/Q levels and zero-stuffs by SPS, emitting one sample per FIR ready pulse.
module qpsk_upsampler #(
  parameter int SPS = 2,
  parameter int AMP = 90,
  parameter int MID = 128
) (
  input  logic            i_clk_x16,
  input  logic            i_rst,
  input  logic            i_en,
  qpsk_upsampler_if.slave bus
);
  localparam int              PW      = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [8:0]      MID9    = 9'(MID);
  localparam logic [8:0]      AMP9    = 9'(AMP);
  localparam logic [8:0]      HI9     = MID9 + AMP9;
  localparam logic [8:0]      LO9     = MID9 - AMP9;
  localparam logic [7:0]      LVL_MID = MID9[7:0];
  localparam logic [7:0]      LVL_HI  = HI9[7:0];
  localparam logic [7:0]      LVL_LO  = LO9[7:0];
  localparam logic [PW-1:0]   PH_LAST = PW'(SPS - 1);

  // A set symbol bit selects the low level, a clear bit the high level.
  function automatic logic [7:0] level(input logic b);
    return b ? LVL_LO : LVL_HI;
  endfunction

  logic [7:0]    sreg_q, sreg_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [7:0]    i_lvl_q, i_lvl_d;
  logic [7:0]    q_lvl_q, q_lvl_d;
  logic          strobe_q, strobe_d;
  logic          underrun_q, underrun_d;
  logic          ready_s;
  logic          transfer_s;
  logic          emit_s;

  // Ready is held low while reset is asserted so nothing is accepted then.
  assign ready_s    = (cnt_q == 3'd0) && !i_rst;
  assign transfer_s = i_en && bus.i_data_valid && ready_s;
  assign emit_s     = i_en && bus.i_fir_ready;

  // Next-state: byte load, symbol emit, bypass and underrun handling.
  always_comb begin
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    i_lvl_d    = i_lvl_q;
    q_lvl_d    = q_lvl_q;
    strobe_d   = strobe_q;
    underrun_d = underrun_q;
    if (i_en) begin
      strobe_d   = 1'b0;
      underrun_d = 1'b0;
      if (emit_s) begin
        phase_d = (phase_q == PH_LAST) ? {PW{1'b0}} : phase_q + PW'(1);
        if (phase_q != {PW{1'b0}}) begin
          i_lvl_d = LVL_MID;
          q_lvl_d = LVL_MID;
          if (transfer_s) begin
            sreg_d = bus.i_data;
            cnt_d  = 3'd4;
          end else begin
            sreg_d = sreg_q;
          end
        end else if (cnt_q != 3'd0) begin
          i_lvl_d  = level(sreg_q[7]);
          q_lvl_d  = level(sreg_q[6]);
          sreg_d   = {sreg_q[5:0], 2'b00};
          cnt_d    = cnt_q - 3'd1;
          strobe_d = 1'b1;
        end else if (transfer_s) begin
          // Bypass: the byte arriving in this slot supplies the symbol directly.
          i_lvl_d  = level(bus.i_data[7]);
          q_lvl_d  = level(bus.i_data[6]);
          sreg_d   = {bus.i_data[5:0], 2'b00};
          cnt_d    = 3'd3;
          strobe_d = 1'b1;
        end else begin
          i_lvl_d    = LVL_MID;
          q_lvl_d    = LVL_MID;
          underrun_d = 1'b1;
        end
      end else if (transfer_s) begin
        sreg_d = bus.i_data;
        cnt_d  = 3'd4;
      end else begin
        sreg_d = sreg_q;
      end
    end else begin
      strobe_d   = strobe_q;
      underrun_d = underrun_q;
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge i_clk_x16) begin
    if (i_rst) begin
      sreg_q     <= 8'h00;
      cnt_q      <= 3'd0;
      phase_q    <= {PW{1'b0}};
      i_lvl_q    <= LVL_MID;
      q_lvl_q    <= LVL_MID;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      sreg_q     <= sreg_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      i_lvl_q    <= i_lvl_d;
      q_lvl_q    <= q_lvl_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.o_data_ready = ready_s;
  assign bus.o_I          = i_lvl_q;
  assign bus.o_Q          = q_lvl_q;
  assign bus.o_sym_strobe = strobe_q;
  assign bus.o_underrun   = underrun_q;
endmodule
